// File: rtl/eth_tx_framer_pkg.sv
// Shared constants, FSM state type and the CRC-32 byte-update helper for the
// Ethernet TX framer.
// Contents: byte width, preamble/SFD bytes, minimum payload length, IFG
// length, CRC-32 polynomial and seed, counter width, state_e, crc32_update().
package eth_tx_framer_pkg;

    localparam int unsigned BYTE_LEN        = 8;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int unsigned PREAMBLE_LEN    = 7;
    localparam int unsigned MIN_PAYLOAD_LEN = 60;
    localparam int unsigned IFG_CYCLES      = 48;
    localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // One shared counter covers preamble, payload/pad length, FCS index and
    // IFG; it must hold MIN_PAYLOAD_LEN and IFG_CYCLES + 1.
    localparam int unsigned CNT_W = $clog2(MIN_PAYLOAD_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } state_e;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                                 input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Byte-level handshake bundle of the Ethernet TX framer.
// master: framer side (drives readclk, outclk, out, done, busy).
// slave : environment side (drives start, inclk, in, in_done, downstream_rdy).
interface eth_tx_framer_if;
    import eth_tx_framer_pkg::*;

    logic                start;
    logic                readclk;
    logic                inclk;
    logic [BYTE_LEN-1:0] in;
    logic                in_done;
    logic                downstream_rdy;
    logic                outclk;
    logic [BYTE_LEN-1:0] out;
    logic                done;
    logic                busy;

    modport master (
        input  start, inclk, in, in_done, downstream_rdy,
        output readclk, outclk, out, done, busy
    );

    modport slave (
        output start, inclk, in, in_done, downstream_rdy,
        input  readclk, outclk, out, done, busy
    );

endinterface

// File: rtl/crc32_byte.sv
// Byte-serial CRC-32 register (reflected, seed all-ones).
// Ports: clk, rst (sync, active high), init (reload seed), inclk (byte
// strobe), in[7:0] (byte), crc[31:0] (running CRC, updates one cycle after
// inclk; not complemented).
module crc32_byte
    import eth_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        inclk,
    input  logic [7:0]  in,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC32_INIT;
        end else if (inclk) begin
            crc_q <= crc32_update(crc_q, in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, payload (one-byte holding register with
// request/response upstream), zero padding to the minimum length, optional
// FCS, then inter-frame gap.
// Ports: clk, rst (sync, active high), bus (eth_tx_framer_if.master).
// Build option: define ETH_TX_FCS_EN to append the 4-byte FCS via crc32_byte;
// without it no CRC logic is built and frames end after payload/pad.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    eth_tx_framer_if.master  bus
);

    localparam logic [CNT_W-1:0] PreLast = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] MinLen  = CNT_W'(MIN_PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] IfgLast = CNT_W'(IFG_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_LEN-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                hold_last_q, hold_last_d;
    logic                pending_q, pending_d;
    logic                got_last_q, got_last_d;
    logic                outclk_q, outclk_d;
    logic [BYTE_LEN-1:0] out_q, out_d;
    logic                done_q, done_d;
    logic                readclk_q, readclk_d;
    logic                busy_q, busy_d;
    logic                can_emit;
    logic                last_data;

`ifdef ETH_TX_FCS_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;
    logic [31:0] fcs;

    assign crc_init = (state_q == StIdle) && bus.start;
    // CRC covers only payload and pad bytes, as they are emitted.
    assign crc_en   = outclk_d && ((state_q == StPayload) || (state_q == StPad));
    assign fcs      = ~crc;

    crc32_byte u_crc (
        .clk   (clk),
        .rst   (rst),
        .init  (crc_init),
        .inclk (crc_en),
        .in    (out_d),
        .crc   (crc)
    );
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        pending_d    = pending_q;
        got_last_d   = got_last_q;
        outclk_d     = 1'b0;
        out_d        = out_q;
        done_d       = 1'b0;
        readclk_d    = 1'b0;
        last_data    = 1'b0;

        // outclk is registered: this cycle's decision appears next cycle, so
        // two consecutive outclk pulses are impossible.
        can_emit = bus.downstream_rdy && !outclk_q;

        // Upstream response; pending_q and hold_valid_q are never both set,
        // so this cannot collide with the emit below.
        if ((state_q == StPayload) && pending_q && bus.inclk) begin
            hold_d       = bus.in;
            hold_valid_d = 1'b1;
            hold_last_d  = bus.in_done;
            got_last_d   = bus.in_done;
            pending_d    = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d      = StPreamble;
                    cnt_d        = '0;
                    hold_valid_d = 1'b0;
                    pending_d    = 1'b0;
                    got_last_d   = 1'b0;
                end
            end
            StPreamble: begin
                if (can_emit) begin
                    outclk_d = 1'b1;
                    out_d    = PREAMBLE_BYTE;
                    if (cnt_q == PreLast) begin
                        state_d = StSfd;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSfd: begin
                if (can_emit) begin
                    outclk_d = 1'b1;
                    out_d    = SFD_BYTE;
                    state_d  = StPayload;
                    cnt_d    = '0;
                end
            end
            StPayload: begin
                if (!hold_valid_q && !pending_q && !got_last_q) begin
                    readclk_d = 1'b1;
                    pending_d = 1'b1;
                end
                if (can_emit && hold_valid_q) begin
                    outclk_d     = 1'b1;
                    out_d        = hold_q;
                    hold_valid_d = 1'b0;
                    if (cnt_q < MinLen) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (hold_last_q) begin
                        if (cnt_q >= MinLast) begin
                            last_data = 1'b1;
                        end else begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                if (can_emit) begin
                    outclk_d = 1'b1;
                    out_d    = '0;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == MinLast) begin
                        last_data = 1'b1;
                    end
                end
            end
`ifdef ETH_TX_FCS_EN
            StFcs: begin
                if (can_emit) begin
                    outclk_d = 1'b1;
                    unique case (cnt_q[1:0])
                        2'd0: out_d = fcs[7:0];
                        2'd1: out_d = fcs[15:8];
                        2'd2: out_d = fcs[23:16];
                        2'd3: out_d = fcs[31:24];
                        default: out_d = fcs[7:0];
                    endcase
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = StIfg;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            StIfg: begin
                // Entered in the done cycle: that cycle, the one after it,
                // then IFG_CYCLES more before returning to idle.
                if (cnt_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (last_data) begin
`ifdef ETH_TX_FCS_EN
            state_d = StFcs;
`else
            state_d = StIfg;
            done_d  = 1'b1;
`endif
            cnt_d = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            pending_q    <= 1'b0;
            got_last_q   <= 1'b0;
            outclk_q     <= 1'b0;
            out_q        <= '0;
            done_q       <= 1'b0;
            readclk_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            pending_q    <= pending_d;
            got_last_q   <= got_last_d;
            outclk_q     <= outclk_d;
            out_q        <= out_d;
            done_q       <= done_d;
            readclk_q    <= readclk_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.outclk  = outclk_q;
    assign bus.out     = out_q;
    assign bus.done    = done_q;
    assign bus.readclk = readclk_q;
    assign bus.busy    = busy_q;

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-004 SHALL have port readclk, output, 1: one-cycle request for the next payload byte from upstream.
REQ-005 SHALL have ports inclk (input, 1) and in (input, BYTE_LEN): payload byte valid when inclk high.
REQ-006 SHALL have port in_done, input, 1: qualified by inclk; marks the last payload byte.
REQ-007 SHALL have port downstream_rdy, input, 1: downstream dibit serializer is idle.
REQ-008 SHALL have ports outclk (output, 1) and out (output, BYTE_LEN): framed byte valid when outclk high.
REQ-009 SHALL have port done, output, 1: high with outclk on the last frame byte only.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-011 SHALL sequence states IDLE -> PREAMBLE -> SFD -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE; PAD is skipped when not needed, and FCS is skipped per REQ-030.
REQ-012 SHALL emit bytes in PREAMBLE as 7 x 0x55, then 1 x 0xD5 in SFD.
REQ-013 SHALL issue outclk only in a cycle where downstream_rdy was high in the previous cycle and no outclk occurred in the previous cycle (outclk registered; minimum spacing 2 cycles).
REQ-014 SHALL keep out stable until the next outclk; out is don't-care when outclk is low.
REQ-015 PAYLOAD byte buffering SHALL:
- use a one-byte holding register;
- assert readclk only when the register is empty and no request is outstanding;
- clear the outstanding flag on inclk, tolerating any upstream read latency.
REQ-016 SHALL not assert readclk after the byte tagged with in_done has been accepted.
REQ-017 SHALL count payload bytes in a counter that saturates at 60; if in_done arrives with count < 60, PAD SHALL emit 0x00 bytes until the count reaches 60.
REQ-018 SHALL compute CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over payload and pad bytes only, updating on each emitted byte.
REQ-019 SHALL emit the FCS in 4 bytes as bitwise NOT of the CRC, least-significant byte first.
REQ-020 SHALL assert done on the final FCS byte, or on the final payload/pad byte when FCS is compiled out.
REQ-021 IFG SHALL last 48 clk cycles after the cycle following done, then return to IDLE with busy low.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL ignore inclk outside PAYLOAD or with no request outstanding.
REQ-024 SHALL treat in_done without inclk as no event.
REQ-025 SHALL always have at least one payload byte per frame; zero-length payload is unsupported.

Reset
REQ-026 When rst is high, all outputs SHALL be 0 on the next edge: outclk, done, readclk, busy, out = 0.
REQ-027 On rst, state SHALL go to IDLE, and the holding register, outstanding flag and counters SHALL clear.
REQ-028 On rst, the CRC register SHALL return to 0xFFFFFFFF.
REQ-029 Reset mid-frame SHALL abort with no done pulse and no further outclk; start is accepted on the first cycle after rst deasserts.

Configuration
REQ-030 With macro ETH_TX_FCS_EN defined, the FCS state and CRC sub-module SHALL be instantiated and 4 FCS bytes appended.
REQ-031 Without ETH_TX_FCS_EN, no CRC logic SHALL exist; PAD goes directly to IFG, and frames are 4 bytes shorter.

Structure
REQ-032 params.vh SHALL hold PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5), PREAMBLE_LEN (7), MIN_PAYLOAD_LEN (60), IFG_CYCLES (48), CRC32_POLY and CRC32_INIT, alongside the existing BYTE_LEN and clog2.
REQ-033 SHALL have one sub-module, crc32_byte: clk, rst, init, inclk, in[7:0]; crc[31:0] updates one cycle after inclk.

Verification
REQ-034 crc32_byte fed ASCII "123456789" from init SHALL give final complemented CRC 0xCBF43926.
REQ-035 Start, then 64 payload bytes with downstream_rdy tied high SHALL give:
- 55 55 55 55 55 55 55 D5;
- 64 payload bytes;
- 4 FCS bytes matching the model;
- done on the 76th byte;
- busy low 48 cycles after.
REQ-036 Start with a 10-byte payload SHALL give 50 bytes 0x00 after the payload, then FCS over 60 bytes; done on byte 72.
REQ-037 downstream_rdy toggled randomly, with upstream latency 3, SHALL give an identical byte sequence and outclk never in consecutive cycles.
REQ-038 rst asserted on the 20th outclk SHALL give all outputs 0 on the next cycle, and no done; a new start then produces a fresh preamble.
REQ-039 Built without ETH_TX_FCS_EN, a 60-byte payload SHALL give done on byte 68 with no FCS bytes.
